// File: rtl/ram_latency_model.sv
// Behavioural multi-cycle RAM behind the memory arbiter: LAT+1 BUSY cycles, then one ACCESS.
// Define RAM_ADDR_CHECK_EN to flag misaligned or out-of-range addresses as ERROR.
module ram_latency_model #(
   parameter int LAT     = 2,
   parameter int DEPTH_W = 14
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ramREN,
   input  logic        ramWEN,
   input  logic [31:0] ramaddr,
   input  logic [31:0] ramstore,
   output logic [31:0] ramload,
   output logic [1:0]  ramstate
);
   localparam int             CW    = (LAT < 1) ? 1 : $clog2(LAT + 1);
   localparam logic [CW-1:0]  LAT_C = CW'(LAT);
   localparam logic [1:0]     FREE   = 2'd0;
   localparam logic [1:0]     BUSY   = 2'd1;
   localparam logic [1:0]     ACCESS = 2'd2;
   localparam logic [1:0]     ERROR  = 2'd3;

   logic               active;
   logic [CW-1:0]      cnt;
   logic [31:0]        cap_addr;
   logic               cap_wen;
   logic [31:0]        rdata;
   logic [31:0]        mem [2**DEPTH_W];

   logic               req, match, err, last, bad_addr;
   logic [DEPTH_W-1:0] idx;

   assign req   = ramREN | ramWEN;
   assign match = active && (ramaddr == cap_addr) && (ramWEN == cap_wen);
   assign idx   = ramaddr[DEPTH_W+1:2];
   assign last  = (cnt == LAT_C);

`ifdef RAM_ADDR_CHECK_EN
   assign bad_addr = req && ((ramaddr[1:0] != 2'b00) || (ramaddr[31:DEPTH_W+2] != '0));
`else
   // Upper and byte-offset bits are ignored, so addresses alias.
   logic unused_addr;
   assign bad_addr    = 1'b0;
   assign unused_addr = ^{ramaddr[31:DEPTH_W+2], ramaddr[1:0]};
`endif

   assign err     = (ramREN & ramWEN) | bad_addr;
   assign ramload = rdata;

   always_comb begin
      ramstate = BUSY;
      if (err)               ramstate = ERROR;
      else if (!req)         ramstate = FREE;
      else if (match && last) ramstate = ACCESS;
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         active   <= 1'b0;
         cnt      <= '0;
         cap_addr <= '0;
         cap_wen  <= 1'b0;
         rdata    <= '0;
         for (int i = 0; i < 2**DEPTH_W; i++) mem[DEPTH_W'(i)] <= '0;
      end else if (err || !req) begin
         active <= 1'b0;
      end else if (!match) begin
         // New or changed request: restart the wait-state count.
         cap_addr <= ramaddr;
         cap_wen  <= ramWEN;
         cnt      <= '0;
         active   <= 1'b1;
         if (LAT == 0 && !ramWEN) rdata <= mem[idx];
      end else if (!last) begin
         cnt <= cnt + CW'(1);
         if ((cnt + CW'(1) == LAT_C) && !cap_wen) rdata <= mem[idx];
      end else begin
         if (cap_wen) mem[idx] <= ramstore;
         active <= 1'b0;
      end
   end
endmodule
